uart_rx_pack64: RTL and testbench

//  Receive-side counterpart of the 64-bit UART byte serializer: collects the byte stream coming
//  out of the UART receiver and reassembles it into 64-bit words for the accelerator core.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_gap_timer.sv | 26 ++
 rtl/uart_rx_pack64.sv | 117 +++++++++++
 tb/tb_uart_rx_pack64.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART byte/word constants and receive FSM state type
package uart_pkg;
  localparam int UART_BYTE_W     = 8;
  localparam int UART_WORD_BYTES = 8;

  typedef enum logic [1:0] {RX_IDLE, RX_COLLECT, RX_DONE} rx_state_t;
endpackage

// File: rtl/uart_gap_timer.sv
// rtl/uart_gap_timer.sv - saturating idle counter that pulses expire after GAP_TIMEOUT quiet cycles
module uart_gap_timer #(
  parameter int GAP_TIMEOUT = 50000,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam logic [CNT_W-1:0] LIMIT = (GAP_TIMEOUT == 0) ? '0 : CNT_W'(GAP_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // A timeout of zero leaves the counter running (saturated) but never expiring.
  assign expire = (GAP_TIMEOUT != 0) && enable && (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clear || expire) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/uart_rx_pack64.sv
// rtl/uart_rx_pack64.sv - reassembles received UART bytes (LSB byte first) into words
module uart_rx_pack64
  import uart_pkg::*;
#(
  parameter int NBYTES      = UART_WORD_BYTES,
  parameter int GAP_TIMEOUT = 50000,
  parameter int CNT_W       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [UART_BYTE_W-1:0]          byte_in,
  input  logic                            byte_valid,
  input  logic                            sync,
  output logic [UART_BYTE_W*NBYTES-1:0]   word_out,
  output logic                            word_valid,
  output logic                            busy,
  output logic                            frame_err
);
  localparam int WORD_W = UART_BYTE_W * NBYTES;
  localparam int BCNT_W = $clog2(NBYTES + 1);
  localparam logic [BCNT_W-1:0] LAST = BCNT_W'(NBYTES - 1);

  rx_state_t                  state, next_state;
  logic [BCNT_W-1:0]          byte_cnt, next_cnt;
  logic [WORD_W-1:0]          shift_q, shift_next;
  logic [WORD_W+UART_BYTE_W-1:0] shift_cat;
  logic                       load_shift, load_word, err;
  logic                       timer_en, gap_expire;

  // New bytes enter at the top so the first byte ends up in the lowest lane.
  assign shift_cat  = {byte_in, shift_q};
  assign shift_next = shift_cat[WORD_W+UART_BYTE_W-1:UART_BYTE_W];

  assign timer_en   = (state == RX_COLLECT) && !byte_valid && !sync;
  assign word_valid = (state == RX_DONE);
  assign busy       = (byte_cnt != '0);

  uart_gap_timer #(
    .GAP_TIMEOUT (GAP_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!timer_en),
    .enable (timer_en),
    .expire (gap_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = byte_cnt;
    load_shift = 1'b0;
    load_word  = 1'b0;
    err        = 1'b0;
    if (sync) begin
      next_state = RX_IDLE;
      next_cnt   = '0;
    end else begin
      case (state)
        RX_COLLECT: begin
          if (byte_valid) begin
            load_shift = 1'b1;
            if (byte_cnt == LAST) begin
              load_word  = 1'b1;
              next_cnt   = '0;
              next_state = RX_DONE;
            end else begin
              next_cnt = byte_cnt + BCNT_W'(1);
            end
          end else if (gap_expire) begin
            next_state = RX_IDLE;
            next_cnt   = '0;
            err        = 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a byte as the first of a new word.
          if (byte_valid) begin
            load_shift = 1'b1;
            if (NBYTES == 1) begin
              load_word  = 1'b1;
              next_cnt   = '0;
              next_state = RX_DONE;
            end else begin
              next_cnt   = BCNT_W'(1);
              next_state = RX_COLLECT;
            end
          end else begin
            next_state = RX_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= '0;
      shift_q   <= '0;
      word_out  <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_cnt  <= next_cnt;
      frame_err <= err;
      if (load_shift) shift_q  <= shift_next;
      if (load_word)  word_out <= shift_next;
    end
  end
endmodule

// File: tb/tb_uart_rx_pack64.sv
// tb/tb_uart_rx_pack64.sv - directed and randomized checks of uart_rx_pack64 against a queue model
module tb_uart_rx_pack64;
  localparam int GAP = 20;

  logic        clk = 1'b0;
  logic        rst, byte_valid, sync;
  logic [7:0]  byte_in;
  logic [63:0] word_out;
  logic        word_valid, busy, frame_err;

  int tests = 0;
  int fails = 0;

  uart_rx_pack64 #(.NBYTES(8), .GAP_TIMEOUT(GAP), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .sync       (sync),
    .word_out   (word_out),
    .word_valid (word_valid),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a list of pending bytes plus a count of quiet cycles since the last one.
  logic [7:0]  mq[$];
  logic [63:0] m_word = '0;
  logic        m_wv = 1'b0, m_ferr = 1'b0, m_init = 1'b0;
  int          m_idle = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_word = '0; m_wv = 1'b0; m_ferr = 1'b0; m_idle = 0; m_init = 1'b1;
    end else begin
      m_wv = 1'b0;
      m_ferr = 1'b0;
      if (sync) begin
        mq.delete();
        m_idle = 0;
      end else if (byte_valid) begin
        mq.push_back(byte_in);
        m_idle = 0;
        if (mq.size() == 8) begin
          for (int k = 0; k < 8; k++) m_word[8*k +: 8] = mq[k];
          m_wv = 1'b1;
          mq.delete();
        end
      end else if (mq.size() != 0) begin
        m_idle++;
        if (m_idle == GAP) begin
          mq.delete();
          m_ferr = 1'b1;
          m_idle = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("word_out",   word_out,         m_word);
      check("word_valid", 64'(word_valid),  64'(m_wv));
      check("busy",       64'(busy),        64'(mq.size() != 0));
      check("frame_err",  64'(frame_err),   64'(m_ferr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in    = b;
    tick();
    byte_valid = 1'b0;
  endtask

  initial begin
    int fe_at, fe_n;
    rst = 1'b1; byte_valid = 1'b0; sync = 1'b0; byte_in = '0;

    // 1: reset and quiet release
    repeat (3) tick();
    check("rst_word", word_out, 64'h0);
    check("rst_flags", {61'h0, word_valid, busy, frame_err}, 64'h0);
    rst = 1'b0;
    repeat (5) tick();
    check("idle_flags", {61'h0, word_valid, busy, frame_err}, 64'h0);

    // 2: spaced bytes, one every 10 clk
    for (int i = 0; i < 8; i++) begin
      put(8'(8'h01 + 8'h22 * i));
      if (i == 7) begin
        check("t2_wv", 64'(word_valid), 64'h1);
        check("t2_word", word_out, 64'hEFCD_AB89_6745_2301);
      end else begin
        repeat (9) tick();
      end
    end
    tick();
    check("t2_after", {62'h0, word_valid, busy}, 64'h0);

    // 3: sixteen back-to-back bytes
    for (int i = 0; i < 16; i++) begin
      put(8'(i));
      if (i == 7) check("t3_w0", word_out, 64'h0706050403020100);
      if (i == 7) check("t3_wv0", 64'(word_valid), 64'h1);
      if (i == 8) check("t3_busy", {62'h0, word_valid, busy}, 64'h1);
    end
    check("t3_wv1", 64'(word_valid), 64'h1);
    check("t3_w1", word_out, 64'h0F0E0D0C0B0A0908);

    // 4: gap timeout
    put(8'h11); put(8'h22); put(8'h33);
    fe_at = -1; fe_n = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (frame_err) begin fe_n++; fe_at = i; end
    end
    check("t4_fe_at", 64'(fe_at), 64'd20);
    check("t4_fe_n", 64'(fe_n), 64'd1);
    check("t4_busy", 64'(busy), 64'h0);
    check("t4_hold", word_out, 64'h0F0E0D0C0B0A0908);
    for (int i = 0; i < 8; i++) put(8'(8'hAA + i));
    check("t4_word", word_out, 64'hB1B0AFAEADACABAA);

    // 5: sync with a colliding byte
    for (int i = 0; i < 5; i++) put(8'(8'h50 + i));
    sync = 1'b1; byte_valid = 1'b1; byte_in = 8'hFF;
    tick();
    sync = 1'b0; byte_valid = 1'b0;
    check("t5_flags", {62'h0, word_valid, busy}, 64'h0);
    for (int i = 0; i < 8; i++) put(8'(8'h10 + i));
    check("t5_word", word_out, 64'h1716151413121110);

    // 6: reset mid-word
    for (int i = 0; i < 4; i++) put(8'(8'hC0 + i));
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_busy", 64'(busy), 64'h0);
    check("t6_word", word_out, 64'h0);
    for (int i = 0; i < 8; i++) put(8'(8'h80 + 8'h11 * i));
    check("t6_word2", word_out, 64'hF7E6D5C4B3A29180);
    tick();

    // Random traffic: bursts with short gaps, long silences, sporadic sync and reset
    for (int n = 0; n < 120; n++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        byte_in    = 8'($urandom);
        byte_valid = ($urandom_range(0, 3) != 0);
        sync       = ($urandom_range(0, 60) == 0);
        rst        = ($urandom_range(0, 400) == 0);
        tick();
        byte_valid = 1'b0; sync = 1'b0; rst = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
      repeat ($urandom_range(0, 30)) tick();
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
